// File: rtl/fifo_pkg.sv
// Shared types, defaults and sizing helper for the programmable synchronous FIFO.
package fifo_pkg;

    typedef enum logic [0:0] {
        RD_REGISTERED = 1'b0,
        RD_FWFT       = 1'b1
    } rd_mode_e;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_AEMPTY_TH  = 1;
    localparam int DEF_FWFT       = 0;

    // Occupancy needs to represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_flag_gen.sv
// Status flags derived purely from the occupancy count; no input can affect them.
module fifo_flag_gen
    import fifo_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_TH  = DEF_DEPTH - 1,
    parameter int AEMPTY_TH = DEF_AEMPTY_TH,
    parameter int CNT_W     = cnt_w(DEF_DEPTH)
) (
    input  logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             almostfull,
    output logic             almostempty
);

    // Threshold comparisons against the registered occupancy.
    always_comb begin
        full        = (count == CNT_W'(DEPTH));
        empty       = (count == {CNT_W{1'b0}});
        almostfull  = (count >= CNT_W'(AFULL_TH)) && (count < CNT_W'(DEPTH));
        almostempty = (count != {CNT_W{1'b0}}) && (count <= CNT_W'(AEMPTY_TH));
    end

endmodule

// File: rtl/sync_fifo_prog_chk.sv
// Parameter legality and structural invariants for sync_fifo_prog.
module sync_fifo_prog_chk
    import fifo_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_TH  = DEF_DEPTH - 1,
    parameter int AEMPTY_TH = DEF_AEMPTY_TH,
    parameter int CNT_W     = cnt_w(DEF_DEPTH)
) (
    input logic             clk,
    input logic             rst,
    input logic [CNT_W-1:0] count,
    input logic             full,
    input logic             empty,
    input logic             wr_ack,
    input logic             overflow
);

    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_prog: DEPTH must be at least 2");
    end
    if ((AFULL_TH < 1) || (AFULL_TH > DEPTH - 1)) begin : g_bad_afull
        $error("sync_fifo_prog: AFULL_TH outside 1..DEPTH-1");
    end
    if ((AEMPTY_TH < 1) || (AEMPTY_TH > DEPTH - 1)) begin : g_bad_aempty
        $error("sync_fifo_prog: AEMPTY_TH outside 1..DEPTH-1");
    end

    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count <= CNT_W'(DEPTH));

    a_full_empty_excl: assert property (@(posedge clk) disable iff (rst)
        !(full && empty));

    a_ack_ovf_excl: assert property (@(posedge clk) disable iff (rst)
        !(wr_ack && overflow));

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable thresholds, flush and selectable FWFT read mode.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AFULL_TH   = DEPTH - 1,
    parameter int AEMPTY_TH  = DEF_AEMPTY_TH,
    parameter int FWFT       = DEF_FWFT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       wr_ack,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       full,
    output logic                       empty,
    output logic                       almostfull,
    output logic                       almostempty,
    output logic [cnt_w(DEPTH)-1:0]    count
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic                  write_ok_s;
    logic                  rd_ok_s;

    // Depth need not be a power of two, so wrap is an explicit compare.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    // Acceptance decisions; a full FIFO still takes a write when a read frees a slot.
    always_comb begin
        rd_ok_s    = rd_en && !empty;
        write_ok_s = wr_en && (!full || rd_ok_s);
    end

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!flush && write_ok_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, occupancy and registered status; flush outranks both requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count     <= {CNT_W{1'b0}};
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count     <= {CNT_W{1'b0}};
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_ok_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({write_ok_s, rd_ok_s})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            wr_ack    <= write_ok_s;
            overflow  <= wr_en && !write_ok_s;
            underflow <= rd_en && !rd_ok_s;
        end
    end

    if (FWFT == int'(RD_FWFT)) begin : g_fwft
        // Head word is presented directly; zero while nothing is stored.
        always_comb begin
            if (empty) begin
                data_out = {DATA_WIDTH{1'b0}};
            end else begin
                data_out = mem_r[rd_ptr_r];
            end
        end
    end else begin : g_registered
        // Read data lands one cycle after an accepted read and holds otherwise.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_out <= {DATA_WIDTH{1'b0}};
            end else if (!flush && rd_ok_s) begin
                data_out <= mem_r[rd_ptr_r];
            end else begin
                data_out <= data_out;
            end
        end
    end

    fifo_flag_gen #(
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH),
        .CNT_W     (CNT_W)
    ) u_flags (
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almostfull  (almostfull),
        .almostempty (almostempty)
    );

    sync_fifo_prog_chk #(
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH),
        .CNT_W     (CNT_W)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .wr_ack   (wr_ack),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench: registered-read and FWFT instances share stimulus and a queue model.
`timescale 1ns/1ps
module tb_sync_fifo_prog;
    import fifo_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = cnt_w(DEPTH);

    logic          clk = 1'b0;
    logic          rst, flush, wr_en, rd_en;
    logic [DW-1:0] data_in;

    logic [DW-1:0] r_dout, f_dout;
    logic          r_ack, r_ovf, r_unf, r_full, r_empty, r_af, r_ae;
    logic          f_ack, f_ovf, f_unf, f_full, f_empty, f_af, f_ae;
    logic [CW-1:0] r_cnt, f_cnt;

    sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(int'(RD_REGISTERED))) u_reg (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(r_dout), .wr_ack(r_ack), .overflow(r_ovf), .underflow(r_unf),
        .full(r_full), .empty(r_empty), .almostfull(r_af), .almostempty(r_ae), .count(r_cnt));

    sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(int'(RD_FWFT))) u_ft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(f_dout), .wr_ack(f_ack), .overflow(f_ovf), .underflow(f_unf),
        .full(f_full), .empty(f_empty), .almostfull(f_af), .almostempty(f_ae), .count(f_cnt));

    always #5 clk = ~clk;

    typedef struct {
        logic          wr_ack;
        logic          ovf;
        logic          unf;
        int            cnt;
        logic [DW-1:0] ft;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] rd_q[$];
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] last_rd = '0;
    int            n_chk = 0;
    int            n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input string tag, input logic ack, input logic ovf, input logic unf,
                           input logic [CW-1:0] cnt, input logic fu, input logic em,
                           input logic af, input logic ae, input exp_t e);
        chk({tag, "_wr_ack"}, ack, e.wr_ack);
        chk({tag, "_overflow"}, ovf, e.ovf);
        chk({tag, "_underflow"}, unf, e.unf);
        chk({tag, "_count"}, cnt, e.cnt);
        chk({tag, "_full"}, fu, e.cnt == DEPTH);
        chk({tag, "_empty"}, em, e.cnt == 0);
        chk({tag, "_almostfull"}, af, (e.cnt >= DEPTH - 1) && (e.cnt < DEPTH));
        chk({tag, "_almostempty"}, ae, (e.cnt > 0) && (e.cnt <= 1));
    endtask

    // Drive one cycle of stimulus and queue the reference model's expectation.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
        exp_t e;
        int   n;
        logic rd_ok, wr_ok;
        @(negedge clk);
        wr_en = w; data_in = d; rd_en = r; flush = f;
        n = model_q.size();
        if (f) begin
            model_q.delete();
            e.wr_ack = 1'b0; e.ovf = 1'b0; e.unf = 1'b0;
        end else begin
            rd_ok = r && (n > 0);
            wr_ok = w && ((n < DEPTH) || rd_ok);
            if (rd_ok) rd_q.push_back(model_q.pop_front());
            if (wr_ok) model_q.push_back(d);
            e.wr_ack = wr_ok; e.ovf = w && !wr_ok; e.unf = r && !rd_ok;
        end
        e.cnt = model_q.size();
        e.ft  = (model_q.size() > 0) ? model_q[0] : '0;
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per clock edge, plus read data when the DUT presents it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_dut("reg", r_ack, r_ovf, r_unf, r_cnt, r_full, r_empty, r_af, r_ae, e);
                chk_dut("ft", f_ack, f_ovf, f_unf, f_cnt, f_full, f_empty, f_af, f_ae, e);
                chk("ft_data_out", f_dout, e.ft);
                if (rd_en && !flush && !r_unf) begin
                    if (rd_q.size() == 0) begin
                        chk("reg_unexpected_read", 1'b1, 1'b0);
                    end else begin
                        last_rd = rd_q.pop_front();
                        chk("reg_read_data", r_dout, last_rd);
                    end
                end else begin
                    chk("reg_data_hold", r_dout, last_rd);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_count", r_cnt, 0);
        chk("rst_empty", r_empty, 1'b1);
        chk("rst_full", r_full, 1'b0);
        chk("rst_af", r_af, 1'b0);
        chk("rst_ae", r_ae, 1'b0);
        chk("rst_status", {r_ack, r_ovf, r_unf}, 3'b000);
        chk("rst_reg_dout", r_dout, 0);
        chk("rst_ft_dout", f_dout, 0);
        rst = 1'b0;

        // Fill, overflow, drain, underflow.
        for (int i = 1; i <= 9; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Simultaneous read/write at empty and at full.
        cycle(1'b1, 16'hABCD, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, DW'(16'h0100 + i), 1'b0, 1'b0);
        cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // FWFT head visibility.
        cycle(1'b1, 16'h1111, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 16'h2222, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Flush with a concurrent write, then reuse.
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(16'h0500 + i), 1'b0, 1'b0);
        cycle(1'b1, 16'hDEAD, 1'b1, 1'b1);
        cycle(1'b1, 16'h5A5A, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Mixed traffic wrapping the pointers, then a long random run.
        for (int i = 0; i < 4; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, DW'($urandom), (i % 4) != 3, 1'b0);
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 50,
                  $urandom_range(0, 49) == 0);

        // Asynchronous reset in the middle of a write burst.
        cycle(1'b1, 16'h7777, 1'b0, 1'b0);
        cycle(1'b1, 16'h8888, 1'b0, 1'b0);
        cycle(1'b1, 16'h9999, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        exp_q.delete(); rd_q.delete(); model_q.delete(); last_rd = '0;
        #1;
        chk("midrst_count", r_cnt, 0);
        chk("midrst_ft_count", f_cnt, 0);
        chk("midrst_empty", r_empty, 1'b1);
        chk("midrst_wr_ack", r_ack, 1'b0);
        chk("midrst_status", {r_ovf, r_unf, f_ack, f_ovf, f_unf}, 5'b00000);
        chk("midrst_reg_dout", r_dout, 0);
        chk("midrst_ft_dout", f_dout, 0);
        wr_en = 1'b0; rd_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(16'hC000 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        @(posedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("read_queue_drained", rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
